instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001: Parameter MEM_SIZE, default 1024, instruction memory size in bytes; power of two, >4.
REQ-002: Parameter RESET_PC, default 64'h0, PC value loaded on reset; word-aligned.
REQ-003: Parameter NOP_WORD, default 32'hD503201F, encoding presented on if_instr for bubbles.
REQ-004: clk  input  1  single clock; all state updates on posedge clk.
REQ-005: reset  input  1  synchronous, active-high reset.
REQ-006: stall  input  1  hold PC and IF/ID register this cycle.
REQ-007: flush  input  1  load bubble into IF/ID register this cycle.
REQ-008: br_taken  input  1  redirect PC to br_target this cycle.
REQ-009: br_target  input  64  byte address of redirect target.
REQ-010: imem_addr  output  64  byte address driven to instruction memory; equals current PC.
REQ-011: imem_instr  input  32  combinational read data from instruction memory for imem_addr.
REQ-012: if_pc  output  64  PC of instruction held in IF/ID register.
REQ-013: if_instr  output  32  instruction held in IF/ID register.
REQ-014: if_valid  output  1  IF/ID register holds a real instruction (0 = bubble).
REQ-015: fault  output  1  sticky fetch fault (misaligned or out-of-bounds address).
REQ-016: fetch_count  output  32  number of valid instructions captured into IF/ID since reset.

Function
REQ-017: imem_addr SHALL be driven combinationally from the PC register, no added latency.
REQ-018: State machine SHALL have two states: RUN and HALT; reset enters RUN.
REQ-019: In RUN, next PC priority SHALL be: br_taken -> br_target; else stall -> PC held; else PC+4.
REQ-020: br_taken SHALL be honoured even when stall is asserted the same cycle.
REQ-021: In RUN with stall=0 and flush=0, IF/ID SHALL capture {PC, imem_instr, valid=1} at posedge; fetch-to-output latency is exactly one cycle.
REQ-022: br_taken with flush=0 and stall=0 SHALL still capture the current (wrong-path) instruction; discard is the caller's job via flush.
REQ-023: flush SHALL load IF/ID with {if_pc=0, if_instr=NOP_WORD, if_valid=0}; flush overrides stall for IF/ID.
REQ-024: stall=1, flush=0 SHALL hold IF/ID contents unchanged.
REQ-025: A candidate next PC with bits[1:0]!=0, or with next PC+3 >= MEM_SIZE, SHALL not be loaded; instead PC holds, fault sets, state goes to HALT.
REQ-026: PC SHALL never wrap; fall-through past the last word (PC = MEM_SIZE-4) SHALL fault per REQ-025.
REQ-027: In HALT, PC SHALL hold, IF/ID SHALL load a bubble every cycle, fault SHALL stay 1; only reset exits HALT.
REQ-028: fetch_count SHALL increment by 1 on each posedge where IF/ID captures with valid=1, saturating at 32'hFFFFFFFF.
REQ-029: The last valid instruction captured before entering HALT SHALL be the one at the PC that was current when the fault was detected.

Reset
REQ-030: On posedge with reset=1: PC=RESET_PC, state=RUN, if_pc=0, if_instr=NOP_WORD, if_valid=0, fault=0, fetch_count=0.
REQ-031: reset SHALL override stall, flush, br_taken and HALT state in the same cycle.
REQ-032: First valid instruction (PC=RESET_PC) SHALL appear on IF/ID at the first posedge with reset=0.
REQ-033: Reset asserted mid-stall or mid-HALT SHALL produce exactly the REQ-030 values after that edge.

Verification
REQ-034: Sequential: reset, then 4 free cycles with imem word = address -> if_pc 0,4,8,12; if_valid=1; fetch_count=4.
REQ-035: Stall: stall=1 for 2 cycles at PC=8 -> imem_addr stays 8, IF/ID holds PC 4 entry, fetch_count unchanged; resumes with PC 8 captured.
REQ-036: Branch+flush: br_taken=1, br_target=0x40, flush=1 -> next edge imem_addr=0x40, if_valid=0, if_instr=NOP_WORD; following edge if_pc=0x40.
REQ-037: Branch during stall: stall=1, br_taken=1, br_target=0x20 -> imem_addr=0x20 after edge, IF/ID held.
REQ-038: Faults: br_target=0x22 -> fault=1, PC held, if_valid=0 thereafter; separately, run to PC=0x3FC -> 0x3FC captured valid, then fault=1 with PC stuck at 0x3FC.
REQ-039: Recovery: reset asserted while in HALT -> fault=0, imem_addr=RESET_PC, fetch_count=0; fetch resumes normally.

Source files
------------

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch -- single-issue instruction fetch stage with an IF/ID register.
//
// Holds the PC and presents it combinationally on imem_addr. On each posedge
// the IF/ID register either captures {PC, imem_instr, valid}, holds (stall),
// or loads a bubble (flush / HALT). A redirect, stall hold or PC+4 fall-through
// that lands on a misaligned or out-of-range address is refused: the PC stays
// put, fault latches and the FSM parks in HALT until reset.
//
// Ports
//   clk          in   clock, all state on posedge
//   reset        in   synchronous active-high reset
//   stall        in   hold PC and IF/ID
//   flush        in   load bubble into IF/ID (wins over stall)
//   br_taken     in   redirect PC to br_target (wins over stall)
//   br_target    in   [63:0] redirect byte address
//   imem_addr    out  [63:0] current PC to instruction memory
//   imem_instr   in   [31:0] combinational read data for imem_addr
//   if_pc        out  [63:0] PC of IF/ID entry
//   if_instr     out  [31:0] instruction of IF/ID entry
//   if_valid     out  IF/ID holds a real instruction
//   fault        out  sticky fetch fault
//   fetch_count  out  [31:0] saturating count of valid IF/ID captures
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int          MEM_SIZE = 1024,
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [31:0] NOP_WORD = 32'hD503201F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    // Highest legal word address; pc + 3 < MEM_SIZE <=> pc <= MEM_SIZE - 4.
    // Comparing this way avoids the carry-out of pc + 3 for huge targets.
    localparam logic [63:0] LAST_WORD = 64'(MEM_SIZE - 4);

    state_t      r_state;
    logic [63:0] r_pc;
    logic [63:0] r_if_pc;
    logic [31:0] r_if_instr;
    logic        r_if_valid;
    logic        r_fault;
    logic [31:0] r_count;

    state_t      w_state_nxt;
    logic [63:0] w_pc_cand;
    logic [63:0] w_pc_nxt;
    logic        w_bad;
    logic        w_fault_nxt;
    logic        w_capture;   // IF/ID takes the current fetch
    logic        w_bubble;    // IF/ID takes a bubble

    always_comb begin
        w_state_nxt = r_state;
        w_pc_cand   = r_pc;
        w_pc_nxt    = r_pc;
        w_bad       = 1'b0;
        w_fault_nxt = r_fault;
        w_capture   = 1'b0;
        w_bubble    = 1'b0;

        case (r_state)
            RUN: begin
                if (br_taken)   w_pc_cand = br_target;
                else if (stall) w_pc_cand = r_pc;
                else            w_pc_cand = r_pc + 64'd4;

                w_bad = (w_pc_cand[1:0] != 2'b00) || (w_pc_cand > LAST_WORD);
                if (w_bad) begin
                    w_fault_nxt = 1'b1;
                    w_state_nxt = HALT;
                end else begin
                    w_pc_nxt = w_pc_cand;
                end

                // The instruction at the PC that raised the fault is still
                // captured this cycle; bubbles start once in HALT.
                if (flush)       w_bubble  = 1'b1;
                else if (!stall) w_capture = 1'b1;
            end
            HALT: begin
                w_bubble = 1'b1;
            end
            default: begin
                w_state_nxt = HALT;
                w_bubble    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= RUN;
            r_pc       <= RESET_PC;
            r_if_pc    <= 64'd0;
            r_if_instr <= NOP_WORD;
            r_if_valid <= 1'b0;
            r_fault    <= 1'b0;
            r_count    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_fault <= w_fault_nxt;
            if (w_bubble) begin
                r_if_pc    <= 64'd0;
                r_if_instr <= NOP_WORD;
                r_if_valid <= 1'b0;
            end else if (w_capture) begin
                r_if_pc    <= r_pc;
                r_if_instr <= imem_instr;
                r_if_valid <= 1'b1;
            end
            if (w_capture && (r_count != 32'hFFFF_FFFF))
                r_count <= r_count + 32'd1;
        end
    end

    assign imem_addr   = r_pc;
    assign if_pc       = r_if_pc;
    assign if_instr    = r_if_instr;
    assign if_valid    = r_if_valid;
    assign fault       = r_fault;
    assign fetch_count = r_count;

endmodule
